// File: rtl/softmax_pkg.sv
// Shared constants and FSM state type for the softmax output packer.
package softmax_pkg;

  localparam int unsigned DATA_SIZE = 16;

  localparam logic [1:0] KEEP_BOTH = 2'b11;
  localparam logic [1:0] KEEP_LO   = 2'b01;

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_HI  = 2'd1,
    S_OUT = 2'd2
  } pack_state_t;

endpackage

// File: rtl/sync_fifo_16.sv
// Single-clock FIFO with combinational read of the head entry.
module sync_fifo_16 #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/softmax_out_pack_16.sv
// Buffers softmax results and packs them two per 32-bit AXI4-Stream beat.
module softmax_out_pack_16
  import softmax_pkg::*;
#(
  parameter int unsigned data_size = DATA_SIZE,
  parameter int unsigned DEPTH     = 64
) (
  input  logic                   axi_clock_i,
  input  logic                   axi_reset_i,
  input  logic [data_size-1:0]   s_data_i,
  input  logic                   s_valid_i,
  input  logic                   s_last_i,
  output logic                   s_space_ok_o,
  output logic                   overflow_o,
  output logic [2*data_size-1:0] m_axis_data_o,
  output logic [1:0]             m_axis_keep_o,
  output logic                   m_axis_last_o,
  output logic                   m_axis_valid_o,
  input  logic                   m_axis_ready_i
);

  logic [data_size:0]       f_rdata;
  logic                     f_empty;
  logic                     f_full;
  logic [$clog2(DEPTH):0]   f_count;
  logic                     f_pop;
  logic                     pop_en;
  logic [data_size-1:0]     r_data;
  logic                     r_last;

  pack_state_t              state;
  logic [data_size-1:0]     lo_q;
  logic [2*data_size-1:0]   data_q;
  logic [1:0]               keep_q;
  logic                     last_q;
  logic                     valid_q;
  logic                     ovf_q;

  sync_fifo_16 #(
    .WIDTH (data_size + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (axi_clock_i),
    .rst   (axi_reset_i),
    .push  (s_valid_i),
    .pop   (f_pop),
    .wdata ({s_last_i, s_data_i}),
    .rdata (f_rdata),
    .empty (f_empty),
    .full  (f_full),
    .count (f_count)
  );

  assign r_data = f_rdata[data_size-1:0];
  assign r_last = f_rdata[data_size];

  // In S_OUT the head entry is consumed only on the handshake cycle.
  assign pop_en = (state == S_LO) || (state == S_HI) ||
                  ((state == S_OUT) && m_axis_ready_i);
  assign f_pop  = pop_en && !f_empty;

  assign s_space_ok_o   = (f_count < ($clog2(DEPTH)+1)'(DEPTH));
  assign overflow_o     = ovf_q;
  assign m_axis_data_o  = data_q;
  assign m_axis_keep_o  = keep_q;
  assign m_axis_last_o  = last_q;
  assign m_axis_valid_o = valid_q;

  // Sticky drop flag: any result offered while the FIFO is full.
  always_ff @(posedge axi_clock_i or posedge axi_reset_i) begin
    if (axi_reset_i)              ovf_q <= 1'b0;
    else if (s_valid_i && f_full) ovf_q <= 1'b1;
  end

  // Packer FSM with registered beat; a handshake with data waiting
  // starts the next beat in the same cycle, exactly as from S_LO.
  always_ff @(posedge axi_clock_i or posedge axi_reset_i) begin
    if (axi_reset_i) begin
      state   <= S_LO;
      lo_q    <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        S_LO: begin
          if (!f_empty) begin
            lo_q <= r_data;
            if (r_last) begin
              data_q  <= {{data_size{1'b0}}, r_data};
              keep_q  <= KEEP_LO;
              last_q  <= 1'b1;
              valid_q <= 1'b1;
              state   <= S_OUT;
            end else begin
              state <= S_HI;
            end
          end
        end
        S_HI: begin
          if (!f_empty) begin
            data_q  <= {r_data, lo_q};
            keep_q  <= KEEP_BOTH;
            last_q  <= r_last;
            valid_q <= 1'b1;
            state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (m_axis_ready_i) begin
            if (f_empty) begin
              data_q  <= '0;
              keep_q  <= '0;
              last_q  <= 1'b0;
              valid_q <= 1'b0;
              state   <= S_LO;
            end else begin
              lo_q <= r_data;
              if (r_last) begin
                data_q  <= {{data_size{1'b0}}, r_data};
                keep_q  <= KEEP_LO;
                last_q  <= 1'b1;
                valid_q <= 1'b1;
                state   <= S_OUT;
              end else begin
                data_q  <= '0;
                keep_q  <= '0;
                last_q  <= 1'b0;
                valid_q <= 1'b0;
                state   <= S_HI;
              end
            end
          end
        end
        default: state <= S_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_out_pack_16.sv
// Self-checking bench for softmax_out_pack_16: table vectors, hand sequences
// for stall/overflow/reset, and a randomized run against a packing model.
module tb_softmax_out_pack_16;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        ready = 1'b0;
  logic        space_ok;
  logic        overflow;
  logic [31:0] m_data;
  logic [1:0]  m_keep;
  logic        m_last;
  logic        m_valid;

  always #5 clk = ~clk;

  softmax_out_pack_16 #(
    .data_size (16),
    .DEPTH     (DEPTH)
  ) dut (
    .axi_clock_i    (clk),
    .axi_reset_i    (rst),
    .s_data_i       (s_data),
    .s_valid_i      (s_valid),
    .s_last_i       (s_last),
    .s_space_ok_o   (space_ok),
    .overflow_o     (overflow),
    .m_axis_data_o  (m_data),
    .m_axis_keep_o  (m_keep),
    .m_axis_last_o  (m_last),
    .m_axis_valid_o (m_valid),
    .m_axis_ready_i (ready)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    logic [15:0] d;
    logic        l;
    bit          has_beat;
    logic [31:0] bd;
    logic [1:0]  bk;
    logic        bl;
  } vec_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  bit    mon_en = 1'b0;

  // Packing model: results pair up in arrival order; a last result closes
  // its beat, alone in lane0 if no partner is waiting.
  bit          pend_v = 1'b0;
  logic [15:0] pend_d = '0;

  function automatic void model_add(logic [15:0] d, logic l);
    beat_t b;
    if (!pend_v) begin
      if (l) begin
        b.d = {16'h0000, d}; b.k = 2'b01; b.l = 1'b1;
        exp_q.push_back(b);
      end else begin
        pend_v = 1'b1;
        pend_d = d;
      end
    end else begin
      b.d = {d, pend_d}; b.k = 2'b11; b.l = l;
      exp_q.push_back(b);
      pend_v = 1'b0;
    end
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [15:0] d, logic l, bit feed);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    if (feed) model_add(d, l);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor at the falling edge: handshakes against the expected
  // queue, and a stalled beat must stay valid and unchanged.
  logic  prev_hold = 1'b0;
  beat_t prev_b;
  beat_t e;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        check("hold_stable", {m_valid, m_data, m_keep, m_last},
              {1'b1, prev_b.d, prev_b.k, prev_b.l});
      if (m_valid && ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h keep %0h last %0h want none",
                   m_data, m_keep, m_last);
        end else begin
          e = exp_q.pop_front();
          check("beat", {m_data, m_keep, m_last}, {e.d, e.k, e.l});
        end
      end
      prev_hold = m_valid && !ready;
      prev_b.d  = m_data;
      prev_b.k  = m_keep;
      prev_b.l  = m_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[7];
  int   accepted;
  logic [15:0] rd;
  logic        rl;

  initial begin
    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_keep", 64'(m_keep), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_space_ok", 64'(space_ok), 64'd1);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    ready = 1'b1;

    // Table vectors: even vector of four, then odd vector A,B,C
    tbl[0] = '{16'h0100, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0};
    tbl[1] = '{16'h0200, 1'b0, 1'b1, 32'h02000100, 2'b11, 1'b0};
    tbl[2] = '{16'h0300, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0};
    tbl[3] = '{16'h0400, 1'b1, 1'b1, 32'h04000300, 2'b11, 1'b1};
    tbl[4] = '{16'hAAAA, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0};
    tbl[5] = '{16'hBBBB, 1'b0, 1'b1, 32'hBBBBAAAA, 2'b11, 1'b0};
    tbl[6] = '{16'hCCCC, 1'b1, 1'b1, 32'h0000CCCC, 2'b01, 1'b1};
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].has_beat) exp_q.push_back('{tbl[i].bd, tbl[i].bk, tbl[i].bl});
      send(tbl[i].d, tbl[i].l, 1'b0);
    end
    wait_drain("table");

    // Long stall: 32 results over 40 cycles with ready low
    ready = 1'b0;
    for (int i = 0; i < 32; i++) send(16'h3000 + 16'(i), (i == 31), 1'b1);
    repeat (8) tick();
    check("stall_valid", 64'(m_valid), 64'd1);
    check("stall_data", 64'(m_data), 64'h30013000);
    check("stall_overflow", 64'(overflow), 64'd0);
    ready = 1'b1;
    wait_drain("stall");
    check("stall_overflow_end", 64'(overflow), 64'd0);

    // Overflow: two results sit in the held beat, DEPTH fill the FIFO,
    // the last of DEPTH+3 is dropped.
    ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) send(16'h4000 + 16'(i), 1'b0, (i < DEPTH + 2));
    check("ovf_space_ok", 64'(space_ok), 64'd0);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_held", 64'(m_data), 64'h40014000);
    ready = 1'b1;
    wait_drain("ovf");
    check("ovf_space_after", 64'(space_ok), 64'd1);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Asynchronous reset mid-vector with beat pending and FIFO occupied
    ready = 1'b0;
    for (int i = 0; i < 10; i++) send(16'h5000 + 16'(i), 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(m_valid), 64'd0);
    check("arst_data", 64'(m_data), 64'd0);
    check("arst_keep", 64'(m_keep), 64'd0);
    check("arst_count", 64'(dut.u_fifo.count), 64'd0);
    check("arst_space_ok", 64'(space_ok), 64'd1);
    check("arst_overflow", 64'(overflow), 64'd0);
    exp_q.delete();
    pend_v = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    ready = 1'b1;
    send(16'h5A00, 1'b0, 1'b1);
    send(16'h5A01, 1'b1, 1'b1);
    send(16'h5A02, 1'b1, 1'b1);
    wait_drain("post_reset");

    // Randomized traffic with toggling ready
    accepted = 0;
    while (accepted < 1000) begin
      ready = 1'($urandom % 2);
      if (($urandom % 10) < 3) begin
        rd = 16'($urandom);
        rl = (($urandom % 4) == 0) || (accepted == 999);
        s_valid = 1'b1;
        s_data  = rd;
        s_last  = rl;
        model_add(rd, rl);
        accepted++;
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    ready   = 1'b1;
    wait_drain("random");
    check("random_overflow", 64'(overflow), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
